// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// default frame/oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned DBIT       = 8;
  localparam int unsigned SB_TICK    = 16;
  localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value is
// a parameter so idle-high lines can come out of reset in their idle state.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with parity and stop-bit checking, 16x oversampled by s_tick.
// Delivers each frame as a one-cycle rx_done_tick with dout and error flags.
module uart_rx_parity #(
  parameter int unsigned DBIT       = uart_pkg::DBIT,
  parameter int unsigned SB_TICK    = uart_pkg::SB_TICK,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);
  import uart_pkg::*;

  localparam int unsigned     NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]      S_MID     = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      S_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      S_STOP    = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);

  rx_state_t       state;
  logic [3:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            p;
  logic            perr_n;
  logic            rx_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      p            <= 1'b0;
      perr_n       <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            s     <= '0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              // A line that is high again at mid-bit was only a glitch.
              if (!rx_s) begin
                s     <= '0;
                n     <= '0;
                p     <= PARITY_ODD;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              p <= p ^ rx_s;
              if (n == N_LAST) begin
                state <= PARITY;
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s      <= '0;
              perr_n <= p ^ rx_s;
              state  <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              dout         <= b;
              parity_err   <= perr_n;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Self-checking bench for uart_rx_parity: a behavioural serializer drives rx,
// and received frames are compared against a frame-level reference model.
module tb_uart_rx_parity;

  localparam int unsigned BIT_CLKS = 64;  // 16 s_tick pulses, one every 4 clk

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout_e, dout_o;
  logic       done_e, done_o, perr_e, perr_o, ferr_e, ferr_o;

  int checks = 0;
  int errors = 0;
  int unsigned tick_div = 0;

  // Captured frames as {dout, parity_err, frame_err}
  logic [9:0] q_e[$];
  logic [9:0] q_o[$];
  logic [9:0] last_exp_e = '0;

  uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout_e), .rx_done_tick(done_e), .parity_err(perr_e), .frame_err(ferr_e)
  );

  uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout_o), .rx_done_tick(done_o), .parity_err(perr_o), .frame_err(ferr_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    s_tick   = (tick_div == 0);
  end

  always @(negedge clk) begin
    if (done_e) q_e.push_back({dout_e, perr_e, ferr_e});
    if (done_o) q_o.push_back({dout_o, perr_o, ferr_o});
  end

  function automatic logic good_parity(input logic [7:0] d, input bit odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic [9:0] model(input logic [7:0] d, input logic par,
                                       input logic stp, input bit odd);
    logic pe;
    pe = (par != good_parity(d, odd));
    return {d, pe, ~stp};
  endfunction

  task automatic drive(input logic v, input int unsigned nclk);
    rx = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
    drive(par, BIT_CLKS);
    if (stp) begin
      drive(1'b1, BIT_CLKS);
    end else begin
      // Short low stop so the line is high again before a re-armed start check.
      drive(1'b0, 48);
      drive(1'b1, 16);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({dout_e, done_e, perr_e, ferr_e} !== 11'b0)
      $display("FAIL reset_outputs: got %h expected %h", {dout_e, done_e, perr_e, ferr_e}, 11'b0);
    if ({dout_e, done_e, perr_e, ferr_e} !== 11'b0) errors++;
    checks++;
    if ({dout_o, done_o, perr_o, ferr_o} !== 11'b0) begin
      $display("FAIL reset_outputs_odd: got %h expected %h", {dout_o, done_o, perr_o, ferr_o}, 11'b0);
      errors++;
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (q_e.size() !== 0) begin
      $display("FAIL reset_no_done: got %0d frames expected 0", q_e.size());
      errors++;
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] d,
                             input logic par, input logic stp);
    logic [9:0] exp, got;
    q_e.delete();
    q_o.delete();
    @(negedge clk);
    send_frame(d, par, stp);
    drive(1'b1, 128);
    exp = model(d, par, stp, 1'b0);
    last_exp_e = exp;
    checks++;
    if (q_e.size() !== 1) begin
      $display("FAIL %s_count: got %0d frames expected 1", name, q_e.size());
      errors++;
    end
    if (q_e.size() > 0) begin
      got = q_e.pop_front();
      checks++;
      if (got !== exp) begin
        $display("FAIL %s_frame: got %h expected %h", name, got, exp);
        errors++;
      end
    end
    checks++;
    if ({dout_e, perr_e, ferr_e} !== exp) begin
      $display("FAIL %s_hold: got %h expected %h", name, {dout_e, perr_e, ferr_e}, exp);
      errors++;
    end
  endtask

  task automatic test_glitch();
    q_e.delete();
    @(negedge clk);
    drive(1'b0, 16);
    drive(1'b1, 200);
    checks++;
    if (q_e.size() !== 0) begin
      $display("FAIL glitch_no_done: got %0d frames expected 0", q_e.size());
      errors++;
    end
    checks++;
    if ({dout_e, perr_e, ferr_e} !== last_exp_e) begin
      $display("FAIL glitch_hold: got %h expected %h", {dout_e, perr_e, ferr_e}, last_exp_e);
      errors++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] junk;
    junk = 8'($urandom);
    q_e.delete();
    @(negedge clk);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive(junk[i], BIT_CLKS);
    drive(junk[3], 32);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    checks++;
    if ({dout_e, done_e, perr_e, ferr_e} !== 11'b0) begin
      $display("FAIL midreset_outputs: got %h expected %h", {dout_e, done_e, perr_e, ferr_e}, 11'b0);
      errors++;
    end
    repeat (800) @(negedge clk);
    checks++;
    if (q_e.size() !== 0) begin
      $display("FAIL midreset_no_partial: got %0d frames expected 0", q_e.size());
      errors++;
    end
    test_single("after_reset_3c", 8'h3C, good_parity(8'h3C, 1'b0), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp0, exp1, got;
    q_o.delete();
    @(negedge clk);
    send_frame(8'h01, good_parity(8'h01, 1'b1), 1'b1);
    send_frame(8'h80, good_parity(8'h80, 1'b1), 1'b1);
    drive(1'b1, 128);
    exp0 = model(8'h01, good_parity(8'h01, 1'b1), 1'b1, 1'b1);
    exp1 = model(8'h80, good_parity(8'h80, 1'b1), 1'b1, 1'b1);
    checks++;
    if (q_o.size() !== 2) begin
      $display("FAIL b2b_count: got %0d frames expected 2", q_o.size());
      errors++;
    end
    if (q_o.size() > 0) begin
      got = q_o.pop_front();
      checks++;
      if (got !== exp0) begin
        $display("FAIL b2b_first: got %h expected %h", got, exp0);
        errors++;
      end
    end
    if (q_o.size() > 0) begin
      got = q_o.pop_front();
      checks++;
      if (got !== exp1) begin
        $display("FAIL b2b_second: got %h expected %h", got, exp1);
        errors++;
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_e[$];
    logic [9:0] exp_o[$];
    logic [9:0] got;
    logic [7:0] d;
    logic       par, stp;
    q_e.delete();
    q_o.delete();
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      par = good_parity(d, 1'b0) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      exp_e.push_back(model(d, par, stp, 1'b0));
      exp_o.push_back(model(d, par, stp, 1'b1));
      send_frame(d, par, stp);
      if (!stp) drive(1'b1, 128);
      else      drive(1'b1, 32 * $urandom_range(0, 2));
    end
    drive(1'b1, 128);
    checks++;
    if (q_e.size() !== exp_e.size()) begin
      $display("FAIL rand_count: got %0d frames expected %0d", q_e.size(), exp_e.size());
      errors++;
    end
    checks++;
    if (q_o.size() !== exp_o.size()) begin
      $display("FAIL rand_count_odd: got %0d frames expected %0d", q_o.size(), exp_o.size());
      errors++;
    end
    while (q_e.size() > 0 && exp_e.size() > 0) begin
      got = q_e.pop_front();
      checks++;
      if (got !== exp_e[0]) begin
        $display("FAIL rand_frame: got %h expected %h", got, exp_e[0]);
        errors++;
      end
      void'(exp_e.pop_front());
    end
    while (q_o.size() > 0 && exp_o.size() > 0) begin
      got = q_o.pop_front();
      checks++;
      if (got !== exp_o[0]) begin
        $display("FAIL rand_frame_odd: got %h expected %h", got, exp_o[0]);
        errors++;
      end
      void'(exp_o.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_single("even_55", 8'h55, 1'b0, 1'b1);
    test_single("parity_ff", 8'hFF, 1'b1, 1'b1);
    test_single("frame_a3", 8'hA3, good_parity(8'hA3, 1'b0), 1'b0);
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

Serial receiver for the UART-with-parity path: consumes the line driven by `uart_tx`, oversamples it with the shared 16x baud tick `s_tick`, and recovers 8-bit data with a parity check and a stop-bit check. Sits directly downstream of `uart_tx`, either looped back on-chip or driven from the external pin. Each frame is delivered as a one-cycle `rx_done_tick` with `dout`, `parity_err` and `frame_err`.

## Interface
- `DBIT`, 8: data bits per frame, sent LSB first.
- `SB_TICK`, 16: `s_tick` count for the stop bit; 16 means one stop bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.

- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-low reset. `reset`=0 at a rising edge resets the block.
- `rx` input 1: serial line; idles high.
- `s_tick` input 1: one-`clk` pulse at 16x the baud rate.
- `dout` output DBIT: last received data word.
- `rx_done_tick` output 1: one-cycle pulse when a frame completes.
- `parity_err` output 1: 1 when the parity bit of the last frame mismatched.
- `frame_err` output 1: 1 when the stop bit of the last frame sampled 0.

## Operation
- `rx` passes through a 2-flop synchronizer. The synchronizer resets to 1. All decisions use the synchronized value `rx_s`.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP. Tick counter `s` is 4 bits. Bit counter `n` is log2(DBIT) bits. Shift register `b` is DBIT bits. Running parity `p` is 1 bit.
- IDLE: when `rx_s`=0, clear `s` and go to START. `s_tick` is ignored in this state.
- START: on each `s_tick`, increment `s`. When `s`=7 (mid-bit):
  - `rx_s`=0: clear `s` and `n`, set `p`=`PARITY_ODD`, go to DATA.
  - `rx_s`=1: the start bit was a glitch; return to IDLE with no output.
- DATA: on the `s_tick` where `s`=15:
  - clear `s`;
  - shift `b` = {`rx_s`, b[DBIT-1:1]};
  - `p` ^= `rx_s`;
  - if `n`=DBIT-1, go to PARITY; otherwise increment `n`.
- PARITY: on the `s_tick` where `s`=15, clear `s`, latch `perr_n` = `p` ^ `rx_s`, go to STOP.
- STOP: on the `s_tick` where `s`=SB_TICK-1:
  - set `dout`=`b`, `parity_err`=`perr_n`, `frame_err`=~`rx_s`;
  - pulse `rx_done_tick`;
  - go to IDLE.
- A frame error does not suppress delivery. `dout` is updated regardless of either error flag.
- `dout`, `parity_err` and `frame_err` hold their values until the next `rx_done_tick`.
- Reset mid-frame: the FSM goes to IDLE, counters clear, and all outputs return to reset values on that edge. No partial frame is delivered.
- If `rx` stays low after STOP (break condition), the FSM enters START again on the next cycle and frames are re-evaluated normally.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `parity_err`=0, `frame_err`=0. FSM is in IDLE, `s`=`n`=0, `b`=0.
- Input latency: 2 `clk` cycles from `rx` to `rx_s`.
- Sample points, counted in `s_tick` pulses after the falling edge is detected:
  - start bit sampled at tick 8;
  - data bit k sampled at 8+16(k+1);
  - parity bit sampled at 8+16(DBIT+1);
  - stop bit sampled at 8+16(DBIT+1)+SB_TICK.
- `rx_done_tick` is registered. It is high for exactly the one `clk` cycle after the edge where STOP's final `s_tick` is processed.
- `dout` and the error flags are valid in the same cycle as `rx_done_tick`.
- With default parameters, the frame ends about half a bit before the nominal stop-bit end. This lets back-to-back frames with zero idle time be received.
- A cycle with `s_tick`=0 never advances `s`.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - default constants `DBIT`=8, `SB_TICK`=16, `OVERSAMPLE`=16.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset value parameter, instantiated with reset value 1.
- Everything else lives in one always block for the FSM and datapath.

## Test plan
- Bench setup: drive `rx` from `uart_tx` loopback or a behavioral serializer, with `s_tick` every 4 `clk` cycles.
- Send 0x55, even parity, parity bit 0 -> one `rx_done_tick`, `dout`=0x55, `parity_err`=0, `frame_err`=0.
- Send 0xFF with parity bit forced to 1 (correct even parity is 0) -> `dout`=0xFF, `parity_err`=1, `frame_err`=0.
- Send 0xA3 with the stop bit forced to 0 -> `dout`=0xA3, `frame_err`=1, `parity_err`=0.
- Drop `rx` low for 4 `s_tick` pulses, then return high -> no `rx_done_tick`, FSM back in IDLE, outputs unchanged.
- Assert `reset`=0 for 1 cycle during data bit 3 of a frame, then send 0x3C -> outputs are 0 after reset, the partial frame is discarded, and 0x3C is received cleanly.
- Send 0x01 and 0x80 back-to-back with no idle gap, with `PARITY_ODD`=1 -> two `rx_done_tick` pulses, `dout`=0x01 then 0x80, no errors.
